smi_line_rx: RTL and testbench

//   Parametrised SMI write-side receiver. Captures asynchronous SMI write strobes from the Pi into a

---
 rtl/smi_line_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_smi_line_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/smi_line_rx.sv
// ============================================================================
// smi_line_rx -- SMI write-side line receiver with ping-pong line buffer.
//
// Asynchronous SMI write strobes from the Pi are synchronised into clk, each
// falling edge of the synced strobe stores one BUS_W word into the current
// write bank. line_sync closes the line: a complete line swaps the banks so
// the serializer can read it through a registered random-access port, a short
// line is flagged as underrun and the read bank keeps the previous line.
//
// Optional feature: define SMI_LINE_CHK_EN to build a running XOR checksum of
// the accepted words; otherwise line_chk is tied to 0.
//
// Ports:
//   clk           system clock (>= 4x SMI strobe rate)
//   global_rst_n  asynchronous reset, active low
//   smi_nwe_pi    SMI write strobe, active low, asynchronous
//   smi_data_pi   SMI data bus, asynchronous
//   line_sync     one-clk pulse, end of current line
//   clr_flags     one-clk pulse, clears overrun/underrun
//   rd_addr       read address into the read bank
//   rd_data       registered read data (1-clk latency, 0 out of range)
//   line_ready    read bank holds a complete line
//   wr_count      words written to the current write bank
//   overrun       sticky: write arrived on a full line
//   underrun      sticky: line_sync arrived on a short line
//   line_chk      XOR checksum of the last swapped line
// ============================================================================
module smi_line_rx #(
    parameter int BUS_W       = 8,
    parameter int LINE_BYTES  = 192,
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2,
    localparam int CNT_W      = $clog2(LINE_BYTES + 1)
) (
    input  logic              clk,
    input  logic              global_rst_n,
    input  logic              smi_nwe_pi,
    input  logic [BUS_W-1:0]  smi_data_pi,
    input  logic              line_sync,
    input  logic              clr_flags,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BUS_W-1:0]  rd_data,
    output logic              line_ready,
    output logic [CNT_W-1:0]  wr_count,
    output logic              overrun,
    output logic              underrun,
    output logic [BUS_W-1:0]  line_chk
);

    localparam int MEM_D = 2 * LINE_BYTES;
    localparam int MEM_W = $clog2(MEM_D);

    // ------------------------------------------------------------------
    // Synchroniser: strobe and data travel side by side so the data seen
    // with the synced strobe edge is the data that was on the bus at the
    // original edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0]            nwe_sync_q, nwe_sync_d;
    logic [SYNC_STAGES-1:0][BUS_W-1:0] data_sync_q, data_sync_d;
    logic                              nwe_prev_q, nwe_prev_d;
    logic                              wr_event;
    logic [BUS_W-1:0]                  wr_word;

    always_comb begin
        nwe_sync_d  = {nwe_sync_q[SYNC_STAGES-2:0], smi_nwe_pi};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], smi_data_pi};
        nwe_prev_d  = nwe_sync_q[SYNC_STAGES-1];
    end

    // One event per strobe: only the 1->0 transition of the synced strobe.
    assign wr_event = nwe_prev_q & ~nwe_sync_q[SYNC_STAGES-1];
    assign wr_word  = data_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            nwe_sync_q  <= '1;
            data_sync_q <= '0;
            nwe_prev_q  <= 1'b1;
        end else begin
            nwe_sync_q  <= nwe_sync_d;
            data_sync_q <= data_sync_d;
            nwe_prev_q  <= nwe_prev_d;
        end
    end

    // ------------------------------------------------------------------
    // Line control: bank select, write counter, sticky flags, checksum.
    // ------------------------------------------------------------------
    logic             wr_bank_q, wr_bank_d;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;
    logic             line_ready_q, line_ready_d;
    logic             overrun_q, overrun_d;
    logic             underrun_q, underrun_d;
    logic             mem_we;
    logic [MEM_W-1:0] mem_waddr;
`ifdef SMI_LINE_CHK_EN
    logic [BUS_W-1:0] chk_run_q, chk_run_d;
    logic [BUS_W-1:0] line_chk_q, line_chk_d;
`endif

    always_comb begin
        wr_bank_d    = wr_bank_q;
        wr_count_d   = wr_count_q;
        line_ready_d = line_ready_q;
        overrun_d    = overrun_q;
        underrun_d   = underrun_q;
        mem_we       = 1'b0;
        mem_waddr    = '0;
`ifdef SMI_LINE_CHK_EN
        chk_run_d    = chk_run_q;
        line_chk_d   = line_chk_q;
`endif

        // Clear first so a set later in this block wins.
        if (clr_flags) begin
            overrun_d  = 1'b0;
            underrun_d = 1'b0;
        end

        // line_sync is resolved before a coincident write so that the word
        // lands at address 0 of the bank that is current afterwards.
        if (line_sync) begin
            if (wr_count_q == CNT_W'(LINE_BYTES)) begin
                wr_bank_d    = ~wr_bank_q;
                line_ready_d = 1'b1;
`ifdef SMI_LINE_CHK_EN
                line_chk_d   = chk_run_q;
`endif
            end else begin
                underrun_d = 1'b1;
            end
            wr_count_d = '0;
`ifdef SMI_LINE_CHK_EN
            chk_run_d  = '0;
`endif
        end

        if (wr_event) begin
            if (int'(wr_count_d) < LINE_BYTES) begin
                mem_we     = 1'b1;
                mem_waddr  = MEM_W'(wr_bank_d ? LINE_BYTES + int'(wr_count_d)
                                              : int'(wr_count_d));
                wr_count_d = wr_count_d + CNT_W'(1);
`ifdef SMI_LINE_CHK_EN
                chk_run_d  = chk_run_d ^ wr_word;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            wr_bank_q    <= 1'b0;
            wr_count_q   <= '0;
            line_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
            underrun_q   <= 1'b0;
`ifdef SMI_LINE_CHK_EN
            chk_run_q    <= '0;
            line_chk_q   <= '0;
`endif
        end else begin
            wr_bank_q    <= wr_bank_d;
            wr_count_q   <= wr_count_d;
            line_ready_q <= line_ready_d;
            overrun_q    <= overrun_d;
            underrun_q   <= underrun_d;
`ifdef SMI_LINE_CHK_EN
            chk_run_q    <= chk_run_d;
            line_chk_q   <= line_chk_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Line storage: one write port, one read port, no reset, so it maps
    // onto a single dual-port block RAM. Bank b occupies
    // [b*LINE_BYTES, (b+1)*LINE_BYTES).
    // ------------------------------------------------------------------
    logic [BUS_W-1:0] mem [MEM_D];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= wr_word;
        end
    end

    // Read bank is always the bank not being written; a swap is therefore
    // visible to reads issued in the cycle after line_sync.
    logic             rd_hit;
    logic [MEM_W-1:0] rd_idx;
    logic [BUS_W-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_hit    = int'(rd_addr) < LINE_BYTES;
        rd_idx    = MEM_W'(~wr_bank_q ? LINE_BYTES + int'(rd_addr) : int'(rd_addr));
        rd_data_d = '0;
        if (rd_hit) begin
            rd_data_d = mem[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_data    = rd_data_q;
    assign line_ready = line_ready_q;
    assign wr_count   = wr_count_q;
    assign overrun    = overrun_q;
    assign underrun   = underrun_q;
`ifdef SMI_LINE_CHK_EN
    assign line_chk   = line_chk_q;
`else
    assign line_chk   = '0;
`endif

endmodule

// File: tb/tb_smi_line_rx.sv
// ============================================================================
// tb_smi_line_rx -- self-checking bench for smi_line_rx (BUS_W=8, 192 words).
// A queue-based line model tracks the expected buffer contents and flags;
// directed line scenarios are followed by randomized lines and reads.
// ============================================================================
module tb_smi_line_rx;

    localparam int BUS_W = 8;
    localparam int LB    = 192;
    localparam int AW    = 8;
    localparam int CW    = $clog2(LB + 1);

    logic             clk = 1'b0;
    logic             global_rst_n = 1'b0;
    logic             smi_nwe_pi = 1'b1;
    logic [BUS_W-1:0] smi_data_pi = '0;
    logic             line_sync = 1'b0;
    logic             clr_flags = 1'b0;
    logic [AW-1:0]    rd_addr = '0;
    logic [BUS_W-1:0] rd_data;
    logic             line_ready;
    logic [CW-1:0]    wr_count;
    logic             overrun;
    logic             underrun;
    logic [BUS_W-1:0] line_chk;

    smi_line_rx #(.BUS_W(BUS_W), .LINE_BYTES(LB), .ADDR_W(AW), .SYNC_STAGES(2)) dut (
        .clk(clk), .global_rst_n(global_rst_n), .smi_nwe_pi(smi_nwe_pi),
        .smi_data_pi(smi_data_pi), .line_sync(line_sync), .clr_flags(clr_flags),
        .rd_addr(rd_addr), .rd_data(rd_data), .line_ready(line_ready),
        .wr_count(wr_count), .overrun(overrun), .underrun(underrun),
        .line_chk(line_chk)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [BUS_W-1:0] m_cur[$];       // words accepted in the current line
    logic [BUS_W-1:0] m_line[LB];     // last completed line
    bit               m_ready, m_over, m_under;
    logic [BUS_W-1:0] m_chk;

    function automatic void m_reset();
        m_cur.delete();
        m_ready = 0; m_over = 0; m_under = 0; m_chk = '0;
    endfunction

    function automatic void m_sync();
        logic [BUS_W-1:0] x;
        if (m_cur.size() == LB) begin
            x = '0;
            foreach (m_cur[i]) begin
                m_line[i] = m_cur[i];
                x ^= m_cur[i];
            end
            m_ready = 1;
`ifdef SMI_LINE_CHK_EN
            m_chk = x;
`endif
        end else begin
            m_under = 1;
        end
        m_cur.delete();
    endfunction

    function automatic void m_write(input logic [BUS_W-1:0] d, input bit with_sync);
        if (with_sync) m_sync();
        if (m_cur.size() < LB) m_cur.push_back(d);
        else m_over = 1;
    endfunction

    // ---------------- stimulus ----------------
    // One strobe: 2 clk low, 2 clk high. The synced falling edge is acted on
    // at the third rising edge after the drive, so a line_sync raised two
    // negedges after the drive coincides with the write event.
    task automatic smi_write(input logic [BUS_W-1:0] d, input bit with_sync);
        @(negedge clk);
        smi_data_pi = d;
        smi_nwe_pi  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        smi_nwe_pi = 1'b1;
        if (with_sync) line_sync = 1'b1;
        @(negedge clk);
        line_sync = 1'b0;
        @(negedge clk);
        m_write(d, with_sync);
    endtask

    task automatic pulse_sync();
        @(negedge clk);
        line_sync = 1'b1;
        @(negedge clk);
        line_sync = 1'b0;
        m_sync();
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        m_over = 0; m_under = 0;
    endtask

    task automatic cmp_all(input string tag);
        check({tag, ".wr_count"},   32'(wr_count),   32'(m_cur.size()));
        check({tag, ".line_ready"}, 32'(line_ready), 32'(m_ready));
        check({tag, ".overrun"},    32'(overrun),    32'(m_over));
        check({tag, ".underrun"},   32'(underrun),   32'(m_under));
        check({tag, ".line_chk"},   32'(line_chk),   32'(m_chk));
    endtask

    // Reads are only meaningful once a complete line exists (RAM has no reset).
    task automatic rd_chk(input string tag, input int a);
        logic [BUS_W-1:0] exp;
        @(negedge clk);
        rd_addr = AW'(a);
        @(negedge clk);
        exp = (a < LB) ? m_line[a] : '0;
        if (m_ready) check($sformatf("%s.rd[%0d]", tag, a), 32'(rd_data), 32'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        global_rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        check("rst.rd_data", 32'(rd_data), 32'h0);
        cmp_all("rst");
        @(negedge clk);
        global_rst_n = 1'b1;
    endtask

    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        check("por.rd_data", 32'(rd_data), 32'h0);
        cmp_all("por");
        global_rst_n = 1'b1;

        // 1: full line 1..192
        for (int i = 1; i <= LB; i++) smi_write(BUS_W'(i), 0);
        cmp_all("t1.pre");
        pulse_sync();
        cmp_all("t1.post");
        check("t1.chk_const", 32'(line_chk),
`ifdef SMI_LINE_CHK_EN
              32'hC0);
`else
              32'h00);
`endif
        rd_chk("t1", 0);
        check("t1.rd0_const", 32'(rd_data), 32'h01);
        rd_chk("t1", 191);
        check("t1.rd191_const", 32'(rd_data), 32'hC0);
        rd_chk("t1", 200);

        // 2: short line -> underrun, read bank unchanged
        for (int i = 0; i < 100; i++) smi_write(BUS_W'($urandom), 0);
        pulse_sync();
        cmp_all("t2");
        rd_chk("t2", 0);
        rd_chk("t2", 150);

        // 3: 200 writes -> overrun on the 193rd
        pulse_clr();
        for (int i = 0; i < LB; i++) smi_write(BUS_W'($urandom), 0);
        cmp_all("t3.full");
        smi_write(8'hA5, 0);
        cmp_all("t3.193");
        for (int i = 0; i < 7; i++) smi_write(BUS_W'($urandom), 0);
        cmp_all("t3.200");
        pulse_clr();
        cmp_all("t3.clr");
        pulse_sync();
        cmp_all("t3.swap");
        rd_chk("t3", 191);

        // 4: next word's event coincident with line_sync
        for (int i = 0; i < LB; i++) smi_write(BUS_W'($urandom), 0);
        smi_write(8'h5A, 1);
        cmp_all("t4.coinc");
        rd_chk("t4", 0);
        rd_chk("t4", 191);
        for (int i = 1; i < LB; i++) smi_write(BUS_W'($urandom), 0);
        pulse_sync();
        cmp_all("t4.next");
        rd_chk("t4n", 0);

        // 5: reset mid-line, then a normal line
        for (int i = 0; i < 50; i++) smi_write(BUS_W'($urandom), 0);
        do_reset();
        for (int i = 0; i < LB; i++) smi_write(BUS_W'($urandom), 0);
        pulse_sync();
        cmp_all("t5");
        rd_chk("t5", 0);
        rd_chk("t5", 95);

        // random lines: length around the boundary, random coincident sync,
        // random flag clears, random reads
        for (int l = 0; l < 8; l++) begin
            int n;
            n = $urandom_range(LB + 4, LB - 4);
            for (int i = 0; i < n; i++) smi_write(BUS_W'($urandom), 0);
            if ($urandom_range(1, 0) == 1) smi_write(BUS_W'($urandom), 1);
            else pulse_sync();
            cmp_all($sformatf("rnd%0d", l));
            for (int r = 0; r < 6; r++) rd_chk($sformatf("rnd%0d", l), $urandom_range(255, 0));
            if ($urandom_range(2, 0) == 0) begin
                pulse_clr();
                cmp_all($sformatf("rnd%0d.clr", l));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
